// File: rtl/port_serial_tx.sv
// Port-bus serial transmitter: CPU writes bytes to DATA, they queue in a FIFO and
// leave on tx as 8N1 frames. STATUS/CONTROL expose FIFO state and a transmit enable.
module port_serial_tx #(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR  = 'h10,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter int unsigned          BIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 do_reset_n,
  input  logic [WORD_SIZE-1:0] portaddr,
  input  logic [WORD_SIZE-1:0] portval,
  input  logic                 portget,
  input  logic                 portset,
  output logic [WORD_SIZE-1:0] portout,
  output logic                 tx
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CYC_W-1:0]     CycLast  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CntFull  = CNT_W'(FIFO_DEPTH);
  localparam logic [WORD_SIZE-1:0] AddrData = BASE_ADDR;
  localparam logic [WORD_SIZE-1:0] AddrStat = BASE_ADDR + WORD_SIZE'(1);
  localparam logic [WORD_SIZE-1:0] AddrCtrl = BASE_ADDR + WORD_SIZE'(2);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Register state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             overflow_q, overflow_d;
  logic             enable_q, enable_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  // Decode and handshake
  logic hit_data, hit_stat, hit_ctrl;
  logic full, empty, busy;
  logic wr_data, push, pop;
  logic [WORD_SIZE-1:0] status;

  // Only the low byte of a DATA write is stored.
  logic unused_portval;
  assign unused_portval = ^portval[WORD_SIZE-1:8];

  assign hit_data = (portaddr == AddrData);
  assign hit_stat = (portaddr == AddrStat);
  assign hit_ctrl = (portaddr == AddrCtrl);

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign busy  = (state_q != StIdle);

  // Full/empty are pre-edge, so a push on full drops even if a pop lands on the same edge.
  assign wr_data = portset & hit_data;
  assign push    = wr_data & ~full;
  assign pop     = (state_q == StIdle) & enable_q & ~empty;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    enable_d   = enable_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_data && full) begin
      overflow_d = 1'b1;
    end
    if (portset && hit_stat && portval[3]) begin
      overflow_d = 1'b0;
    end
    if (portset && hit_ctrl) begin
      enable_d = portval[0];
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          shift_d = mem_q[rd_ptr_q];
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cyc_q == CycLast) begin
          state_d = StData;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      StData: begin
        if (cyc_q == CycLast) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      StStop: begin
        if (cyc_q == CycLast) begin
          state_d = StIdle;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered, so derive it from the state being entered.
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge do_reset_n) begin
    if (!do_reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      enable_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= portval[7:0];
    end
  end

  always_comb begin
    status              = '0;
    status[0]           = full;
    status[1]           = empty;
    status[2]           = busy;
    status[3]           = overflow_q;
    status[4]           = enable_q;
    status[8 +: CNT_W]  = count_q;
  end

  // Undriven reads return 0 so several responders can be ORed onto one bus.
  always_comb begin
    portout = '0;
    if (portget) begin
      if (hit_stat) begin
        portout = status;
      end else if (hit_ctrl) begin
        portout = {{(WORD_SIZE-1){1'b0}}, enable_q};
      end
    end
  end

  assign tx = tx_q;

endmodule
